// File: rtl/gen_bridge.sv
// Dead-time H-bridge gate generator: alternating A/B half-periods whose
// length is CNT_MIN plus a loadable adjust value, with a dead band of
// DEAD_CYCLES low cycles at the start of every half.
module gen_bridge #(
    parameter int CLK_MHZ       = 100,
    parameter int FREQ_KHZ_MIN  = 100,
    parameter int FREQ_KHZ_MAX  = 400,
    parameter int GEN_PARAMETER = 255,
    parameter int DEAD_CYCLES   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic [$clog2(GEN_PARAMETER+1)-1:0]     inp,
    input  logic                                   run,
    output logic                                   out_a,
    output logic                                   out_b,
    output logic                                   sync,
    output logic                                   busy
);

    localparam int W        = $clog2(GEN_PARAMETER + 1);
    localparam int CNT_MIN  = 500 * CLK_MHZ / FREQ_KHZ_MAX;
    localparam int CNT_SPAN = CNT_MIN + GEN_PARAMETER;      // pos reaches CNT_SPAN-1
    localparam int CNT_SLOW = 500 * CLK_MHZ / FREQ_KHZ_MIN;
    localparam int CW       = $clog2((CNT_SPAN > CNT_SLOW) ? CNT_SPAN : CNT_SLOW);

    localparam logic [W-1:0]  GEN_MAX     = W'(GEN_PARAMETER);
    localparam logic [CW-1:0] DEAD        = CW'(DEAD_CYCLES);
    localparam logic [CW-1:0] LEN_BASE_M1 = CW'(CNT_MIN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_A    = 2'd1;
    localparam logic [1:0] ST_B    = 2'd2;

    generate
        if (DEAD_CYCLES < 1 || DEAD_CYCLES >= CNT_MIN) begin : g_bad_dead
            $error("gen_bridge: DEAD_CYCLES must be >= 1 and < CNT_MIN");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] pos_q, pos_d;
    logic [CW-1:0] last_q, last_d;      // L-1 of the running half, latched at its start
    logic [W-1:0]  gen_param_q, gen_param_d;
    logic          out_a_q, out_a_d;
    logic          out_b_q, out_b_d;
    logic          sync_q, sync_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] last_new_s;

    // Half length for a half starting now uses the value held before this edge.
    assign last_new_s = LEN_BASE_M1 + CW'(gen_param_q);

    // Next-state, counter, parameter load and output decode.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        last_d      = last_q;
        gen_param_d = gen_param_q;

        if (en) begin
            gen_param_d = (inp > GEN_MAX) ? GEN_MAX : inp;
        end else begin
            gen_param_d = gen_param_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_A;
                    pos_d   = {CW{1'b0}};
                    last_d  = last_new_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_A: begin
                if (pos_q == last_q) begin
                    state_d = ST_B;
                    pos_d   = {CW{1'b0}};
                    last_d  = last_new_s;
                end else begin
                    pos_d = pos_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_B: begin
                // Stop is honoured only here, so an A/B pair is never cut short.
                if (pos_q == last_q) begin
                    pos_d = {CW{1'b0}};
                    if (run) begin
                        state_d = ST_A;
                        last_d  = last_new_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pos_d = pos_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = {CW{1'b0}};
            end
        endcase

        out_a_d = (state_d == ST_A) && (pos_d >= DEAD);
        out_b_d = (state_d == ST_B) && (pos_d >= DEAD);
        sync_d  = (state_d == ST_A) && (pos_d == {CW{1'b0}});
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset forces everything low immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= {CW{1'b0}};
            last_q      <= {CW{1'b0}};
            gen_param_q <= {W{1'b0}};
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            last_q      <= last_d;
            gen_param_q <= gen_param_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
        end
    end

    assign out_a = out_a_q;
    assign out_b = out_b_q;
    assign sync  = sync_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_gen_bridge.sv
// Bench for gen_bridge: elapsed-time reference model compared every cycle,
// interval measurements pinned to hand-computed values, random soak.
module tb_gen_bridge;

    localparam int GEN     = 255;
    localparam int DEAD    = 8;
    localparam int CNT_MIN = 500 * 100 / 400;

    logic       clk = 1'b0;
    logic       rst, en, run;
    logic [7:0] inp;
    logic       out_a, out_b, sync, busy;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int cyc     = 0;

    // reference model: phase 0 idle, 1 A, 2 B; el = cycles since half start
    int m_ph = 0, m_el = 0, m_len = 0, m_gen = 0;
    logic e_a = 1'b0, e_b = 1'b0, e_sync = 1'b0, e_busy = 1'b0;

    // measurements
    int  last_sync = -1, sync_period = 0, sync_cnt = 0;
    int  a_rise = 0, b_rise = 0, a_high = 0, b_high = 0;
    int  low_cnt = 0, last_gap = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    gen_bridge dut (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .run(run),
        .out_a(out_a), .out_b(out_b), .sync(sync), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            mis_cnt++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // what the next clock edge must produce, given the inputs now applied
    task automatic model_advance();
        int ng;
        if (rst) begin
            m_ph = 0; m_el = 0; m_gen = 0;
        end else begin
            ng = en ? ((int'(inp) > GEN) ? GEN : int'(inp)) : m_gen;
            if (m_ph == 0) begin
                if (run) begin m_ph = 1; m_el = 0; m_len = CNT_MIN + m_gen; end
            end else begin
                m_el++;
                if (m_el == m_len) begin
                    m_el = 0;
                    if (m_ph == 1) begin
                        m_ph = 2; m_len = CNT_MIN + m_gen;
                    end else if (run) begin
                        m_ph = 1; m_len = CNT_MIN + m_gen;
                    end else begin
                        m_ph = 0;
                    end
                end
            end
            m_gen = ng;
        end
        e_a    = (m_ph == 1) && (m_el >= DEAD);
        e_b    = (m_ph == 2) && (m_el >= DEAD);
        e_sync = (m_ph == 1) && (m_el == 0);
        e_busy = (m_ph != 0);
    endtask

    task automatic step();
        model_advance();
        @(negedge clk);
        cyc++;
        chk("outputs{a,b,sync,busy}", {out_a, out_b, sync, busy}, {e_a, e_b, e_sync, e_busy});
        chk("overlap", int'(out_a & out_b), 0);
        if (sync) begin
            if (last_sync >= 0) sync_period = cyc - last_sync;
            last_sync = cyc;
            sync_cnt++;
        end
        if (out_a && !prev_a) begin
            a_rise = cyc; last_gap = low_cnt;
            chk("dead_gap_a", int'(low_cnt >= DEAD), 1);
        end
        if (out_b && !prev_b) begin
            b_rise = cyc; last_gap = low_cnt;
            chk("dead_gap_b", int'(low_cnt >= DEAD), 1);
        end
        if (!out_a && prev_a) a_high = cyc - a_rise;
        if (!out_b && prev_b) b_high = cyc - b_rise;
        if (out_a || out_b) low_cnt = 0; else low_cnt++;
        prev_a = out_a;
        prev_b = out_b;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_sync(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            step();
            if (sync) at = cyc;
        end
        if (at < 0) begin
            cmp_cnt++; mis_cnt++;
            $display("FAIL wait_sync: no sync within %0d cycles", budget);
        end
    endtask

    task automatic load(input int v);
        en = 1'b1; inp = 8'(v);
        step();
        en = 1'b0;
    endtask

    initial begin
        int s, t, found;
        rst = 1'b1; en = 1'b0; run = 1'b0; inp = 8'd0;

        // reset state, with en/run asserted to show reset wins
        steps(3);
        en = 1'b1; inp = 8'd77; run = 1'b1;
        step();
        chk("reset_outputs", {out_a, out_b, sync, busy}, 4'b0000);
        en = 1'b0; run = 1'b0;
        rst = 1'b0;
        steps(4);
        chk("idle_busy", int'(busy), 0);

        // defaults, inp=0: 400 kHz
        load(0);
        run = 1'b1;
        steps(800);
        chk("p0_sync_period", sync_period, 250);
        chk("p0_a_high", a_high, 117);
        chk("p0_b_high", b_high, 117);
        chk("p0_dead_gap", last_gap, 8);

        // inp=255: L=380
        load(255);
        steps(2400);
        chk("p255_sync_period", sync_period, 760);
        chk("p255_a_high", a_high, 372);
        chk("p255_b_high", b_high, 372);

        // mid-half load only affects the next half
        load(0);
        wait_sync(2000, t);
        wait_sync(2000, t);
        wait_sync(2000, s);
        steps(50);
        en = 1'b1; inp = 8'd100;
        step();
        en = 1'b0;
        wait_sync(2000, t);
        chk("midload_b_rise_offset", b_rise - s, 133);
        chk("midload_sync_period", t - s, 350);
        chk("midload_b_high", b_high, 217);

        // run dropped at pos 10 of A: pair completes, then idle
        wait_sync(2000, s);
        steps(10);
        run = 1'b0;
        found = -1;
        for (int i = 0; i < 1000 && found < 0; i++) begin
            step();
            if (!busy) found = cyc;
        end
        chk("stop_busy_fall", found - s, 450);
        t = sync_cnt;
        steps(600);
        chk("stop_no_more_sync", sync_cnt, t);

        // reset mid-B with out_b high, then restart
        run = 1'b1;
        found = -1;
        for (int i = 0; i < 1000 && found < 0; i++) begin
            step();
            if (out_b && cyc == b_rise) found = cyc;
        end
        chk("rst_found_b_rise", int'(found >= 0), 1);
        steps(52);
        chk("rst_pre_out_b", int'(out_b), 1);
        rst = 1'b1;
        step();
        chk("rst_mid_outputs", {out_a, out_b, sync, busy}, 4'b0000);
        rst = 1'b0;
        step();
        chk("restart_sync_busy", {out_a, sync, busy}, 3'b011);
        steps(7);
        chk("restart_a_pre", int'(out_a), 0);
        step();
        chk("restart_a_rise", int'(out_a), 1);

        // random soak
        for (int i = 0; i < 15000; i++) begin
            rst = ($urandom_range(0, 1999) == 0);
            en  = ($urandom_range(0, 49) == 0);
            inp = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) run = ~run;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
